// File: rtl/mem_pkg.sv
// Shared memory-interface types for the pipeline/memory boundary.
package mem_pkg;

  localparam int WORD_W     = 32;
  localparam int MEM_STRB_W = WORD_W / 8;

  typedef logic [31:0] Addr;
  typedef logic [31:0] Word;
  typedef logic        Bool;

  // Arbiter ownership of the single memory port.
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DM = 2'd2
  } arb_state_t;

endpackage

// File: rtl/memory_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and the data stage.
// Data wins contention unless fetch has been refused STARVE_LIMIT times in a row.
// Fetch responses made stale by a flush are completed on the bus but not delivered.
module memory_port_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  input  logic                if_flush,
  output logic [DATA_W-1:0]   if_rdata,
  output logic                if_valid,
  output logic                if_stall,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic [DATA_W-1:0]   dm_rdata,
  output logic                dm_done,
  output logic                dm_stall,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wstrb,
  input  logic                mem_ack,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  arb_state_t       state;
  logic [CNT_W-1:0] starve_cnt;
  Bool              drop;

  // A side whose completion pulse is showing still has its old request up,
  // so it is not eligible for a new grant in that cycle.
  logic if_ok;
  logic dm_ok;
  logic forced_if;

  assign if_ok     = if_req & ~if_valid;
  assign dm_ok     = dm_req & ~dm_done;
  assign forced_if = if_ok & (starve_cnt == CNT_MAX);

  // Stalls follow the live requests, masked by the registered completion pulses.
  assign if_stall = if_req & ~if_valid;
  assign dm_stall = dm_req & ~dm_done;

  // Arbitration FSM, request register, starvation counter and response registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      starve_cnt <= '0;
      drop       <= 1'b0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      if_rdata   <= '0;
      dm_rdata   <= '0;
      if_valid   <= 1'b0;
      dm_done    <= 1'b0;
    end else begin
      if_valid <= 1'b0;
      dm_done  <= 1'b0;
      case (state)
        IDLE: begin
          if (dm_ok && !forced_if) begin
            mem_req   <= 1'b1;
            mem_we    <= dm_we;
            mem_addr  <= dm_addr;
            mem_wdata <= dm_wdata;
            mem_wstrb <= dm_wstrb;
            state     <= BUSY_DM;
            if (if_req && (starve_cnt != CNT_MAX)) begin
              starve_cnt <= starve_cnt + CNT_W'(1);
            end
          end else if (if_ok) begin
            mem_req    <= 1'b1;
            mem_we     <= 1'b0;
            mem_addr   <= if_addr;
            mem_wdata  <= '0;
            mem_wstrb  <= '0;
            state      <= BUSY_IF;
            starve_cnt <= '0;
          end
        end
        BUSY_IF: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            state     <= IDLE;
            drop      <= 1'b0;
            // A flush in the ack cycle itself still kills the response.
            if (!(drop || if_flush)) begin
              if_rdata <= mem_rdata;
              if_valid <= 1'b1;
            end
          end else if (if_flush) begin
            drop <= 1'b1;
          end
        end
        BUSY_DM: begin
          if (mem_ack) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_wstrb <= '0;
            state     <= IDLE;
            dm_done   <= 1'b1;
            // Stores leave the last load result in place.
            if (!mem_we) begin
              dm_rdata <= mem_rdata;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Directed bench for memory_port_arbiter: inputs change and outputs are sampled
// just after the falling edge; the memory side is driven by the bench per test.
module tb_memory_port_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_flush;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;
  logic              if_stall;
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_wstrb;
  logic [DATA_W-1:0] dm_rdata;
  logic              dm_done;
  logic              dm_stall;
  logic              mem_req;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [3:0]        mem_wstrb;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  int passed;
  int total;

  memory_port_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .STARVE_LIMIT(4)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .if_req   (if_req),
    .if_addr  (if_addr),
    .if_flush (if_flush),
    .if_rdata (if_rdata),
    .if_valid (if_valid),
    .if_stall (if_stall),
    .dm_req   (dm_req),
    .dm_we    (dm_we),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_wstrb (dm_wstrb),
    .dm_rdata (dm_rdata),
    .dm_done  (dm_done),
    .dm_stall (dm_stall),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; if_req = 1'b1; dm_req = 1'b1; dm_we = 1'b0;
    if_addr = 32'h10; dm_addr = 32'h80; if_flush = 1'b0;
    dm_wdata = '0; dm_wstrb = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (3) tick();
    total++; if (mem_req !== 1'b0) $display("FAIL reset_mem_req: got %0h want 0", mem_req); else passed++;
    total++; if (if_valid !== 1'b0) $display("FAIL reset_if_valid: got %0h want 0", if_valid); else passed++;
    total++; if (dm_done !== 1'b0) $display("FAIL reset_dm_done: got %0h want 0", dm_done); else passed++;
    total++; if (mem_addr !== 32'h0) $display("FAIL reset_mem_addr: got %0h want 0", mem_addr); else passed++;
    rst_n = 1'b1;
    tick();
    total++; if (mem_req !== 1'b1) $display("FAIL release_mem_req: got %0h want 1", mem_req); else passed++;
    total++; if (mem_addr !== 32'h80) $display("FAIL release_mem_addr: got %0h want 80", mem_addr); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222; if_req = 1'b0;
    tick();
    total++; if (dm_done !== 1'b1) $display("FAIL release_dm_done: got %0h want 1", dm_done); else passed++;
    total++; if (dm_rdata !== 32'h1111_2222) $display("FAIL release_dm_rdata: got %0h want 11112222", dm_rdata); else passed++;
    mem_ack = 1'b0; dm_req = 1'b0;
    tick();
    total++; if (mem_req !== 1'b0) $display("FAIL no_dup_grant: got %0h want 0", mem_req); else passed++;
    total++; if (dm_done !== 1'b0) $display("FAIL done_one_cycle: got %0h want 0", dm_done); else passed++;
  endtask

  task automatic test_fetch_only();
    if_req = 1'b1; if_addr = 32'h40;
    #1;
    total++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_req: got %0h want 1", if_stall); else passed++;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0 || mem_wstrb !== 4'h0)
      $display("FAIL fetch_bus: got req=%0h addr=%0h we=%0h strb=%0h want 1/40/0/0", mem_req, mem_addr, mem_we, mem_wstrb);
    else passed++;
    total++; if (if_stall !== 1'b1) $display("FAIL fetch_stall_busy: got %0h want 1", if_stall); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    tick();
    total++; if (if_valid !== 1'b1) $display("FAIL fetch_valid: got %0h want 1", if_valid); else passed++;
    total++; if (if_rdata !== 32'h0050_0093) $display("FAIL fetch_rdata: got %0h want 00500093", if_rdata); else passed++;
    total++; if (if_stall !== 1'b0) $display("FAIL fetch_stall_done: got %0h want 0", if_stall); else passed++;
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
    total++; if (if_valid !== 1'b0 || mem_req !== 1'b0) $display("FAIL fetch_after: got valid=%0h req=%0h want 0/0", if_valid, mem_req); else passed++;
  endtask

  task automatic test_contention();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF; dm_wstrb = 4'hF;
    if_req = 1'b1; if_addr = 32'h44;
    tick();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h100 || mem_wdata !== 32'hDEAD_BEEF || mem_wstrb !== 4'hF)
      $display("FAIL contend_data_first: got req=%0h we=%0h addr=%0h wdata=%0h strb=%0h want 1/1/100/deadbeef/f", mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    tick();
    total++; if (dm_done !== 1'b1) $display("FAIL contend_store_done: got %0h want 1", dm_done); else passed++;
    total++; if (dm_rdata !== 32'h1111_2222) $display("FAIL store_keeps_rdata: got %0h want 11112222", dm_rdata); else passed++;
    dm_req = 1'b0; dm_we = 1'b0; mem_ack = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h44 || mem_wstrb !== 4'h0)
      $display("FAIL contend_fetch_next: got req=%0h we=%0h addr=%0h strb=%0h want 1/0/44/0", mem_req, mem_we, mem_addr, mem_wstrb);
    else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h0000_AAAA;
    tick();
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_AAAA) $display("FAIL contend_fetch_data: got valid=%0h data=%0h want 1/aaaa", if_valid, if_rdata); else passed++;
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
  endtask

  // The fetch side lowers its request in each done cycle so that the only slot
  // fetch can win is the one forced by the starvation counter.
  task automatic test_starvation();
    int grants;
    grants = 0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h300; if_addr = 32'h48;
    for (int n = 0; n <= 13; n++) begin
      if (n % 3 == 1) begin
        total++;
        if (mem_req !== 1'b1 || mem_addr !== ((grants < 4) ? 32'h300 : 32'h48))
          $display("FAIL starve_grant%0d: got req=%0h addr=%0h want 1/%0h", grants, mem_req, mem_addr, (grants < 4) ? 32'h300 : 32'h48);
        else passed++;
        grants++;
      end
      if (n == 12) begin
        total++; if (dut.starve_cnt !== 3'd4) $display("FAIL starve_cnt_sat: got %0d want 4", dut.starve_cnt); else passed++;
      end
      if_req  = (n % 3 != 2);
      mem_ack = (n % 3 == 1);
      mem_rdata = 32'h0000_0300 + 32'(n);
      tick();
    end
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_030D) $display("FAIL starve_fetch_valid: got valid=%0h data=%0h want 1/30d", if_valid, if_rdata); else passed++;
    total++; if (dut.starve_cnt !== 3'd0) $display("FAIL starve_cnt_clear: got %0d want 0", dut.starve_cnt); else passed++;
    if_req = 1'b0; dm_req = 1'b0; mem_ack = 1'b0;
    tick();
  endtask

  task automatic test_flush();
    if_req = 1'b1; if_addr = 32'h180;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h180) $display("FAIL flush_first_bus: got req=%0h addr=%0h want 1/180", mem_req, mem_addr); else passed++;
    if_flush = 1'b1;
    tick();
    if_flush = 1'b0; if_addr = 32'h200;
    tick();
    total++; if (if_valid !== 1'b0 || mem_addr !== 32'h180) $display("FAIL flush_wait: got valid=%0h addr=%0h want 0/180", if_valid, mem_addr); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0BAD;
    tick();
    total++; if (if_valid !== 1'b0) $display("FAIL flush_no_valid: got %0h want 0", if_valid); else passed++;
    total++; if (if_rdata !== 32'h0000_030D) $display("FAIL flush_rdata_kept: got %0h want 30d", if_rdata); else passed++;
    total++; if (if_stall !== 1'b1) $display("FAIL flush_stall: got %0h want 1", if_stall); else passed++;
    mem_ack = 1'b0;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h200) $display("FAIL flush_refetch: got req=%0h addr=%0h want 1/200", mem_req, mem_addr); else passed++;
    mem_ack = 1'b1; mem_rdata = 32'h0000_0013;
    tick();
    total++; if (if_valid !== 1'b1 || if_rdata !== 32'h0000_0013) $display("FAIL flush_new_valid: got valid=%0h data=%0h want 1/13", if_valid, if_rdata); else passed++;
    mem_ack = 1'b0; if_req = 1'b0;
    tick();
  endtask

  task automatic test_wait_states();
    dm_req = 1'b1; dm_we = 1'b1; dm_addr = 32'h400; dm_wdata = 32'h1234_5678; dm_wstrb = 4'h3;
    tick();
    for (int w = 1; w <= 5; w++) begin
      total++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h400 || mem_wdata !== 32'h1234_5678 || mem_wstrb !== 4'h3 || dm_done !== 1'b0 || dm_stall !== 1'b1)
        $display("FAIL wait_stable%0d: got req=%0h addr=%0h wdata=%0h strb=%0h done=%0h stall=%0h want 1/400/12345678/3/0/1",
                 w, mem_req, mem_addr, mem_wdata, mem_wstrb, dm_done, dm_stall);
      else passed++;
      mem_ack = (w == 5);
      tick();
    end
    total++; if (dm_done !== 1'b1) $display("FAIL wait_done: got %0h want 1", dm_done); else passed++;
    mem_ack = 1'b0; dm_req = 1'b0; dm_we = 1'b0;
    tick();
    dm_req = 1'b1; dm_addr = 32'h500;
    tick();
    total++; if (mem_req !== 1'b1 || mem_addr !== 32'h500) $display("FAIL rst_mid_bus: got req=%0h addr=%0h want 1/500", mem_req, mem_addr); else passed++;
    rst_n = 1'b0;
    #1;
    total++; if (mem_req !== 1'b0 || mem_addr !== 32'h0) $display("FAIL rst_mid_async: got req=%0h addr=%0h want 0/0", mem_req, mem_addr); else passed++;
    dm_req = 1'b0;
    tick();
    rst_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
    tick();
    mem_ack = 1'b0;
    total++; if (dm_done !== 1'b0 || mem_req !== 1'b0) $display("FAIL rst_mid_no_done: got done=%0h req=%0h want 0/0", dm_done, mem_req); else passed++;
    total++; if (dm_rdata !== 32'h0) $display("FAIL rst_mid_rdata: got %0h want 0", dm_rdata); else passed++;
    tick();
    total++; if (dm_done !== 1'b0) $display("FAIL rst_mid_late_done: got %0h want 0", dm_done); else passed++;
  endtask

  initial begin
    passed = 0;
    total  = 0;
    test_reset();
    test_fetch_only();
    test_contention();
    test_starvation();
    test_flush();
    test_wait_states();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
